// File: rtl/fir3x_pkg.sv
// fir3x_pkg
// Shared definitions for the 3-lane parallel-to-serial block (fir3x_p2s):
//   W_DEFAULT     default sample width in bits
//   SHIFT_DEFAULT default arithmetic right shift of the scaled build
//                 (coefficient sum 2190 is close to 2^11)
//   lane_t        2-bit lane index type, LANE0..LANE2 are its legal values
//   SAT16_MAX/MIN signed 16-bit limits used by the saturating scaler
package fir3x_pkg;

  localparam int W_DEFAULT     = 32;
  localparam int SHIFT_DEFAULT = 11;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE0 = 2'd0;
  localparam lane_t LANE1 = 2'd1;
  localparam lane_t LANE2 = 2'd2;

  localparam int SAT16_MAX = 32767;
  localparam int SAT16_MIN = -32768;

endpackage

// File: rtl/fir3x_p2s_sat.sv
// fir3x_p2s_sat
// Purely combinational scaler used by the FIR3X_P2S_SCALE_EN build of
// fir3x_p2s: arithmetic right shift by SHIFT, then clamp into the signed
// 16-bit range and sign-extend back to W bits.
// Ports:
//   din   input  W  signed sample to scale
//   dout  output W  shifted, saturated, sign-extended sample
module fir3x_p2s_sat
  import fir3x_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);

  localparam logic signed [W-1:0] SAT_HI = W'(SAT16_MAX);
  localparam logic signed [W-1:0] SAT_LO = W'(SAT16_MIN);

  logic signed [W-1:0] shifted;

  // Shift first so the clamp sees the scaled value; the comparison is done
  // at full width, so values far outside 16 bits saturate correctly.
  always_comb begin
    shifted = din >>> SHIFT;
    if (shifted > SAT_HI) begin
      dout = SAT_HI;
    end else if (shifted < SAT_LO) begin
      dout = SAT_LO;
    end else begin
      dout = shifted;
    end
  end

endmodule

// File: rtl/fir3x_p2s.sv
// fir3x_p2s
// Accepts one 3-lane block word (y0,y1,y2 in time order) and emits its
// lanes one per cycle on a valid/ready serial stream. A new word can be
// loaded in the same cycle the last lane of the current word leaves, so a
// continuously fed stream runs at one sample per cycle.
// Build option: define FIR3X_P2S_SCALE_EN to pass every output sample
// through fir3x_p2s_sat (>>> SHIFT, saturate to 16 bits); without it the
// lanes are emitted unmodified. Handshake timing is the same in both builds.
// Ports:
//   clk       input     clock, rising edge
//   reset     input     synchronous, active-low
//   in_valid  input     word present on in_y0..in_y2
//   in_ready  output    word accepted this cycle
//   in_y0..2  input  W  lanes of the word
//   out_valid output    out_data holds a sample
//   out_ready input     downstream takes the sample this cycle
//   out_data  output W  serial sample
//   out_lane  output 2  lane index of out_data
//   out_last  output    high with lane 2
module fir3x_p2s
  import fir3x_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int SHIFT = SHIFT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_y0,
  input  logic signed [W-1:0] in_y1,
  input  logic signed [W-1:0] in_y2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output lane_t               out_lane,
  output logic                out_last
);

  logic signed [W-1:0] lane0;
  logic signed [W-1:0] lane1;
  logic signed [W-1:0] lane2;
  lane_t               cnt;
  logic                full;

  logic                inFire;
  logic                outFire;
  logic                atLast;
  logic signed [W-1:0] selLane;
  logic signed [W-1:0] scaled;

  assign atLast  = (cnt == LANE2);
  assign outFire = out_valid & out_ready;
  assign inFire  = in_valid & in_ready;

  // The register can take a word when it is empty, or when the last lane is
  // leaving this very cycle. Held low during reset so nothing is accepted
  // while the holding register is being cleared.
  assign in_ready = reset & (~full | (atLast & out_ready));

  // Load has priority: an input transfer while full can only happen on the
  // last-lane output transfer, so reloading covers that case as well.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full  <= 1'b0;
      cnt   <= LANE0;
      lane0 <= '0;
      lane1 <= '0;
      lane2 <= '0;
    end else if (inFire) begin
      full  <= 1'b1;
      cnt   <= LANE0;
      lane0 <= in_y0;
      lane1 <= in_y1;
      lane2 <= in_y2;
    end else if (outFire) begin
      if (atLast) begin
        full <= 1'b0;
        cnt  <= LANE0;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

  // Lane selection; cnt never reaches 3, so the default arm covers lane 2.
  always_comb begin
    selLane = lane2;
    case (cnt)
      LANE0:   selLane = lane0;
      LANE1:   selLane = lane1;
      default: selLane = lane2;
    endcase
  end

`ifdef FIR3X_P2S_SCALE_EN
  fir3x_p2s_sat #(
    .W     (W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (selLane),
    .dout (scaled)
  );
`else
  assign scaled = selLane;
`endif

  // Outputs are forced to their idle values while reset is asserted, even
  // before the first clock edge has cleared the holding register.
  assign out_valid = reset & full;
  assign out_data  = reset ? scaled : '0;
  assign out_lane  = reset ? cnt : LANE0;
  assign out_last  = reset & atLast;

endmodule

// File: doc/fir3x_p2s.md
FIR3X_P2S -- requirements
Module: fir3x_p2s

Interface
REQ-001 Parameter W, default 32: sample width in bits, all data ports signed two's complement.
REQ-002 Parameter SHIFT, default 11: arithmetic right-shift applied when FIR3X_P2S_SCALE_EN is defined (coefficient sum 2190 ≈ 2^11).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; 0 = reset, sampled on rising clk edge.
REQ-005 in_valid  input  1  3-lane block word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_y0, in_y1, in_y2  input  W each  lanes of one block word, time order y0 (sample 3k), y1 (3k+1), y2 (3k+2).
REQ-008 out_valid  output  1  out_data holds a sample.
REQ-009 out_ready  input  1  downstream consumes the sample this cycle.
REQ-010 out_data  output  W  serial sample stream.
REQ-011 out_lane  output  2  lane index (0,1,2) of out_data; 3 never driven.
REQ-012 out_last  output  1  high with lane 2 (last sample of a block word).

Function
REQ-013 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer on out_valid=1 and out_ready=1.
REQ-014 Holding register: 3 lanes plus lane counter cnt (0..2) plus full flag; out_valid = full; out_data = lane[cnt]; out_lane = cnt; out_last = (cnt==2).
REQ-015 in_ready = !full OR (cnt==2 AND out_ready), combinational, so back-to-back words stream without bubbles.
REQ-016 Input transfer with register empty: load lanes, cnt<=0, full<=1; first sample visible the next cycle (latency 1).
REQ-017 Output transfer with cnt<2: cnt<=cnt+1, lanes held.
REQ-018 Output transfer with cnt==2 and simultaneous input transfer: reload lanes, cnt<=0, full stays 1.
REQ-019 Output transfer with cnt==2 and no input transfer: full<=0, cnt<=0.
REQ-020 out_valid=1 and out_ready=0: out_data, out_lane, out_last stable until transfer.
REQ-021 Sustained throughput: one sample per cycle with in_valid and out_ready held high; one word accepted every 3 cycles.
REQ-022 in_y* ignored whenever no input transfer occurs.

Reset
REQ-023 reset=0 at a clock edge: full<=0, cnt<=0, lanes<=0; out_valid=0, out_data=0, out_lane=0, out_last=0, in_ready=0 while reset asserted.
REQ-024 Reset mid-word discards remaining lanes; first cycle after release in_ready=1, out_valid=0.

Configuration
REQ-025 Macro FIR3X_P2S_SCALE_EN defined: out_data = lane[cnt] >>> SHIFT, saturated to signed 16-bit range [-32768, 32767], sign-extended to W.
REQ-026 Macro undefined: out_data = lane[cnt] unmodified; timing and handshake identical in both builds.

Structure
REQ-027 Shared package fir3x_pkg holds W default, SHIFT default, lane-index constants LANE0/LANE1/LANE2, and the sat16 limits.
REQ-028 One sub-module fir3x_p2s_sat (combinational shift-and-saturate) instantiated only under FIR3X_P2S_SCALE_EN; remainder in fir3x_p2s.

Verification
REQ-029 Reset held 2 cycles, release, no input -> out_valid=0, in_ready=1, out_data=0.
REQ-030 One word (10,20,30), out_ready=1 -> cycles 1..3 after accept: out_data 10/20/30, out_lane 0/1/2, out_last only on 30; then out_valid=0.
REQ-031 Words (1,2,3),(4,5,6) back-to-back, out_ready=1 -> six consecutive valid samples 1..6, no bubble, second word accepted in the cycle sample 3 transfers.
REQ-032 Word (7,8,9), out_ready=0 for 4 cycles after accept -> out_data=7, out_lane=0 stable, in_ready=0; then stream 7,8,9.
REQ-033 Reset asserted after sample 1 of word (11,12,13) -> 12,13 never emitted; next word (14,15,16) emitted intact.
REQ-034 SCALE_EN build, word (4096, 2^30, -2^30) -> out_data 2, 32767, -32768; non-SCALE build -> 4096, 2^30, -2^30.
